// File: rtl/kamacore_pkg.sv
// kamacore shared types: decoded EX operation encoding, iterative unit
// states, helper classifiers and constants used by the execute stage.
package kamacore_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_LUI    = 5'd10,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } ex_op_t;

  typedef enum logic [1:0] {
    IT_IDLE = 2'd0,
    IT_RUN  = 2'd1,
    IT_DONE = 2'd2
  } iter_state_t;

  localparam int                  MAX_XLEN  = 64;
  localparam logic [MAX_XLEN-1:0] DIV0_QUOT = '1;
  localparam logic [4:0]          REG_ZERO  = 5'd0;

  function automatic logic is_mul(input ex_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div(input ex_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/kamacore_muldiv_iter.sv
// Iterative RV32M/RV64M unit: IDLE/RUN/DONE FSM with a down-counter, a
// shift-add multiplier retiring MUL_STEP bits per cycle and a restoring
// radix-2 divider. The divider only exists when KAMACORE_EX_DIV_EN is defined.
module kamacore_muldiv_iter
  import kamacore_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            start_i,
  input  ex_op_t          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            ack_i,
  output logic            idle_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int               CNT_W   = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(XLEN / MUL_STEP);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  iter_state_t         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  ex_op_t              op_q, op_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [2*XLEN-1:0]   aext, mul_init, mul_acc_step;
  logic [XLEN-1:0]     mul_res;
  logic                start_ok;

`ifdef KAMACORE_EX_DIV_EN
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  SMIN    = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0] orig_a_q, orig_a_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            negq_q, negq_d, negr_q, negr_d;
  logic            div0_q, div0_d, ovf_q, ovf_d;
  logic            div_sgn, a_neg, b_neg, div_zero_in, div_ovf_in;
  logic [XLEN:0]   div_shift, div_diff;
  logic [XLEN-1:0] quo_fix, rem_fix, div_res;
`endif

  assign idle_o = (state_q == IT_IDLE);
  assign busy_o = (state_q == IT_RUN);
  assign done_o = (state_q == IT_DONE);

`ifdef KAMACORE_EX_DIV_EN
  assign start_ok = start_i && (is_mul(op_i) || is_div(op_i));
`else
  assign start_ok = start_i && is_mul(op_i);
`endif

  // Operand conditioning at start: sign/zero-extend the multiplicand and
  // pre-load the correction term that makes a signed multiplier work with
  // an unsigned bit-serial walk (sext(b) = b - b[msb]*2^XLEN).
  always_comb begin
    aext     = (op_i inside {OP_MULH, OP_MULHSU}) ? {{XLEN{a_i[XLEN-1]}}, a_i}
                                                  : {{XLEN{1'b0}}, a_i};
    mul_init = ((op_i == OP_MULH) && b_i[XLEN-1]) ? -(aext << XLEN) : '0;
  end

  // One multiplier iteration: add the shifted multiplicand for each of the
  // MUL_STEP low multiplier bits.
  always_comb begin
    mul_acc_step = acc_q;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (mplier_q[k]) begin
        mul_acc_step = mul_acc_step + (mcand_q << k);
      end
    end
  end

`ifdef KAMACORE_EX_DIV_EN
  // Divider operand signs, special cases and one restoring step.
  always_comb begin
    div_sgn     = op_i inside {OP_DIV, OP_REM};
    a_neg       = div_sgn && a_i[XLEN-1];
    b_neg       = div_sgn && b_i[XLEN-1];
    div_zero_in = (b_i == '0);
    div_ovf_in  = div_sgn && (a_i == SMIN) && (b_i == '1);
    div_shift   = {rem_q, quo_q[XLEN-1]};
    div_diff    = div_shift - {1'b0, dvsr_q};
  end
`endif

  // Next-state logic for the FSM, counter and datapath registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`ifdef KAMACORE_EX_DIV_EN
    orig_a_d = orig_a_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IT_IDLE: begin
        if (start_ok) begin
          op_d    = op_i;
          state_d = IT_RUN;
          if (is_mul(op_i)) begin
            acc_d    = mul_init;
            mcand_d  = aext;
            mplier_d = b_i;
            cnt_d    = MUL_CNT;
          end
`ifdef KAMACORE_EX_DIV_EN
          else begin
            orig_a_d = a_i;
            negq_d   = a_neg ^ b_neg;
            negr_d   = a_neg;
            div0_d   = div_zero_in;
            ovf_d    = div_ovf_in;
            rem_d    = '0;
            quo_d    = a_neg ? -a_i : a_i;
            dvsr_d   = b_neg ? -b_i : b_i;
            cnt_d    = (div_zero_in || div_ovf_in) ? CNT_ONE : DIV_CNT;
          end
`endif
        end
      end
      IT_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (is_mul(op_q)) begin
          acc_d    = mul_acc_step;
          mcand_d  = mcand_q << MUL_STEP;
          mplier_d = mplier_q >> MUL_STEP;
        end
`ifdef KAMACORE_EX_DIV_EN
        else begin
          rem_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], ~div_diff[XLEN]};
        end
`endif
        if (cnt_q == CNT_ONE) begin
          state_d = IT_DONE;
        end
      end
      IT_DONE: begin
        if (ack_i) begin
          state_d = IT_IDLE;
        end
      end
      default: state_d = IT_IDLE;
    endcase
  end

  // State register; flush abandons the operation and clears the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IT_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`ifdef KAMACORE_EX_DIV_EN
      orig_a_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else if (flush_i) begin
      state_q <= IT_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`ifdef KAMACORE_EX_DIV_EN
      orig_a_q <= orig_a_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Final result selection: low/high product half, or signed-corrected
  // quotient/remainder with the divide-by-zero and overflow overrides.
  always_comb begin
    mul_res = (op_q == OP_MUL) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
`ifdef KAMACORE_EX_DIV_EN
    quo_fix = negq_q ? -quo_q : quo_q;
    rem_fix = negr_q ? -rem_q : rem_q;
    if (div0_q) begin
      quo_fix = DIV0_QUOT[XLEN-1:0];
      rem_fix = orig_a_q;
    end else if (ovf_q) begin
      quo_fix = orig_a_q;
      rem_fix = '0;
    end
    div_res  = (op_q inside {OP_REM, OP_REMU}) ? rem_fix : quo_fix;
    result_o = is_div(op_q) ? div_res : mul_res;
`else
    result_o = mul_res;
`endif
  end

endmodule

// File: rtl/kamacore_stage_ex_mc.sv
// kamacore multi-cycle execute stage: single-cycle ALU, iterative mul/div
// unit, valid/ready output register exported as a forwarding source.
// KAMACORE_EX_DIV_EN enables the divider; without it DIV-family ops finish
// in one cycle with result 0 and out_tag[0] set as an illegal-op flag.
module kamacore_stage_ex_mc
  import kamacore_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 8,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  ex_op_t           in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [4:0]       in_rd,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [4:0]       out_rd,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data
);

  localparam int SHW = $clog2(XLEN);
`ifdef KAMACORE_EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_result_q, out_result_d;
  logic [4:0]       out_rd_q, out_rd_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic [TAG_W-1:0] pend_tag_q, pend_tag_d;

  logic             it_idle, it_busy, it_done, it_start, it_ack;
  logic [XLEN-1:0]  it_result, alu_res;
  logic [TAG_W-1:0] alu_tag;
  logic [SHW-1:0]   shamt;
  logic             in_is_iter, accept, alu_load, it_load;

  kamacore_muldiv_iter #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush),
    .start_i  (it_start),
    .op_i     (in_op),
    .a_i      (in_rs1),
    .b_i      (in_rs2),
    .ack_i    (it_ack),
    .idle_o   (it_idle),
    .busy_o   (it_busy),
    .done_o   (it_done),
    .result_o (it_result)
  );

  // Handshake: accept only when the iterative unit is idle and the output
  // register is free or draining this cycle; flush blocks acceptance.
  always_comb begin
    in_is_iter = is_mul(in_op) || (DIV_EN && is_div(in_op));
    it_ack     = !out_valid_q || out_ready;
    in_ready   = !flush && it_idle && it_ack;
    accept     = in_valid && in_ready;
    it_start   = accept && in_is_iter;
    alu_load   = accept && !in_is_iter;
    it_load    = it_done && it_ack && !flush;
  end

  // Single-cycle ALU; DIV-family ops land here only when the divider is absent.
  always_comb begin
    shamt   = in_rs2[SHW-1:0];
    alu_res = '0;
    alu_tag = in_tag;
    unique case (in_op)
      OP_ADD:  alu_res = in_rs1 + in_rs2;
      OP_SUB:  alu_res = in_rs1 - in_rs2;
      OP_SLL:  alu_res = in_rs1 << shamt;
      OP_SLT:  alu_res = XLEN'($signed(in_rs1) < $signed(in_rs2));
      OP_SLTU: alu_res = XLEN'(in_rs1 < in_rs2);
      OP_XOR:  alu_res = in_rs1 ^ in_rs2;
      OP_SRL:  alu_res = in_rs1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(in_rs1) >>> shamt);
      OP_OR:   alu_res = in_rs1 | in_rs2;
      OP_AND:  alu_res = in_rs1 & in_rs2;
      OP_LUI:  alu_res = in_rs2;
      default: alu_res = '0;
    endcase
    if (!DIV_EN && is_div(in_op)) begin
      alu_tag[0] = 1'b1;
    end
  end

  // Output register next state: an ALU load or an iterative completion
  // wins over draining, so a consume and a refill can share a cycle.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_tag_d    = out_tag_q;
    pend_rd_d    = pend_rd_q;
    pend_tag_d   = pend_tag_q;
    if (it_start) begin
      pend_rd_d  = in_rd;
      pend_tag_d = in_tag;
    end
    if (alu_load) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_res;
      out_rd_d     = in_rd;
      out_tag_d    = alu_tag;
    end else if (it_load) begin
      out_valid_d  = 1'b1;
      out_result_d = it_result;
      out_rd_d     = pend_rd_q;
      out_tag_d    = pend_tag_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // EX/MEM register; flush only needs to drop the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= REG_ZERO;
      out_tag_q    <= '0;
      pend_rd_q    <= REG_ZERO;
      pend_tag_q   <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_tag_q    <= out_tag_d;
      pend_rd_q    <= pend_rd_d;
      pend_tag_q   <= pend_tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_rd     = out_rd_q;
  assign out_tag    = out_tag_q;
  assign busy       = it_busy;
  assign fwd_valid  = out_valid_q && (out_rd_q != REG_ZERO);
  assign fwd_rd     = out_rd_q;
  assign fwd_data   = out_result_q;

endmodule

// File: tb/tb_kamacore_stage_ex_mc.sv
// Directed bench for kamacore_stage_ex_mc (XLEN=32, MUL_STEP=1). The divider
// checks follow KAMACORE_EX_DIV_EN: full DIV/REM results when defined,
// one-cycle illegal-op completion otherwise.
module tb_kamacore_stage_ex_mc;
  import kamacore_pkg::*;

  localparam int XLEN     = 32;
  localparam int TAG_W    = 8;
  localparam int MUL_STEP = 1;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic             busy, fwd_valid;
  ex_op_t           in_op;
  logic [XLEN-1:0]  in_rs1, in_rs2, out_result, fwd_data;
  logic [4:0]       in_rd, out_rd, fwd_rd;
  logic [TAG_W-1:0] in_tag, out_tag;
  ex_op_t           fop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kamacore_stage_ex_mc #(
    .XLEN     (XLEN),
    .TAG_W    (TAG_W),
    .MUL_STEP (MUL_STEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_tag    (out_tag),
    .busy       (busy),
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input ex_op_t op, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [4:0] rd,
                               input logic [TAG_W-1:0] tag);
    in_valid = v;
    in_op    = op;
    in_rs1   = a;
    in_rs2   = b;
    in_rd    = rd;
    in_tag   = tag;
  endtask

  // Present an ALU op and check it lands one edge later; in_valid is left
  // high so consecutive calls exercise back-to-back issue.
  task automatic issueAlu(input string name, input ex_op_t op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [4:0] rd,
                          input logic [XLEN-1:0] exp);
    applyStimulus(1'b1, op, a, b, rd, 8'h3C);
    #1;
    checkOutput({name, "_in_ready"}, in_ready, 1);
    tick();
    checkOutput({name, "_valid"}, out_valid, 1);
    checkOutput({name, "_result"}, out_result, exp);
    checkOutput({name, "_rd"}, out_rd, rd);
  endtask

  // Issue one iterative op, count busy cycles until the result appears.
  task automatic runIter(input string name, input ex_op_t op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [4:0] rd,
                         input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp,
                         input int expBusy);
    int busyCnt;
    int leak;
    busyCnt = 0;
    leak    = 0;
    applyStimulus(1'b1, op, a, b, rd, tag);
    #1;
    checkOutput({name, "_accept_ready"}, in_ready, 1);
    tick();
    applyStimulus(1'b0, OP_ADD, '0, '0, 5'd0, '0);
    for (int c = 0; c < 200 && !out_valid; c++) begin
      if (busy) busyCnt++;
      if (in_ready) leak++;
      tick();
    end
    checkOutput({name, "_valid"}, out_valid, 1);
    checkOutput({name, "_result"}, out_result, exp);
    checkOutput({name, "_rd"}, out_rd, rd);
    checkOutput({name, "_tag"}, out_tag, tag);
    checkOutput({name, "_busy_cycles"}, busyCnt, expBusy);
    checkOutput({name, "_ready_while_busy"}, leak, 0);
    tick();
    checkOutput({name, "_drained"}, out_valid, 0);
  endtask

  // Watchdog so a stuck design still terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, OP_ADD, '0, '0, 5'd0, '0);
    tick();
    tick();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_result", out_result, 0);
    checkOutput("rst_out_rd", out_rd, 0);
    checkOutput("rst_out_tag", out_tag, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fwd_valid", fwd_valid, 0);
    rst = 1'b0;

    // ADD latency and forwarding outputs
    applyStimulus(1'b1, OP_ADD, 32'd5, 32'd7, 5'd3, 8'h11);
    #1;
    checkOutput("add_in_ready", in_ready, 1);
    tick();
    checkOutput("add_valid", out_valid, 1);
    checkOutput("add_result", out_result, 32'd12);
    checkOutput("add_fwd_valid", fwd_valid, 1);
    checkOutput("add_fwd_rd", fwd_rd, 5'd3);
    checkOutput("add_fwd_data", fwd_data, 32'd12);
    checkOutput("add_tag", out_tag, 8'h11);

    // back-to-back ALU ops, one result per edge
    issueAlu("sub", OP_SUB, 32'd5, 32'd7, 5'd4, 32'hFFFF_FFFE);
    issueAlu("sra", OP_SRA, 32'h8000_0000, 32'h0000_0024, 5'd5, 32'hF800_0000);
    issueAlu("srl", OP_SRL, 32'h8000_0000, 32'd4, 5'd6, 32'h0800_0000);
    issueAlu("sll", OP_SLL, 32'd1, 32'd31, 5'd7, 32'h8000_0000);
    issueAlu("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'd1);
    issueAlu("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd9, 32'd0);
    issueAlu("xor", OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd10, 32'h0FF0_0FF0);
    issueAlu("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd11, 32'hF000_F000);
    issueAlu("or", OP_OR, 32'hF0F0_F0F0, 32'h0F00_0000, 5'd12, 32'hFFF0_F0F0);
    issueAlu("lui", OP_LUI, 32'h0000_DEAD, 32'h1234_5000, 5'd13, 32'h1234_5000);
    issueAlu("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd2, 5'd14, 32'd1);
    applyStimulus(1'b0, OP_ADD, '0, '0, 5'd0, '0);
    tick();
    checkOutput("alu_drain", out_valid, 0);

    // multiplier
    runIter("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 8'h22, 32'hFFFF_FFFE, 32);
    runIter("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 8'h23, 32'h0000_0000, 32);
    runIter("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd8, 8'h24, 32'hFFFF_FFEB, 32);
    runIter("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd9, 8'h25, 32'hFFFF_FFFF, 32);

`ifdef KAMACORE_EX_DIV_EN
    runIter("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 8'h30, 32'h8000_0000, 1);
    runIter("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 8'h31, 32'h0000_0000, 1);
    runIter("divu_zero", OP_DIVU, 32'd100, 32'd0, 5'd12, 8'h32, 32'hFFFF_FFFF, 1);
    runIter("remu_zero", OP_REMU, 32'd100, 32'd0, 5'd13, 8'h33, 32'd100, 1);
    runIter("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd14, 8'h34, 32'hFFFF_FFFD, 32);
    runIter("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd15, 8'h35, 32'hFFFF_FFFF, 32);
    runIter("divu", OP_DIVU, 32'd1000, 32'd7, 5'd16, 8'h36, 32'd142, 32);
    fop = OP_DIV;
`else
    applyStimulus(1'b1, OP_DIV, 32'd100, 32'd7, 5'd11, 8'h40);
    #1;
    checkOutput("div_illegal_ready", in_ready, 1);
    tick();
    applyStimulus(1'b0, OP_ADD, '0, '0, 5'd0, '0);
    checkOutput("div_illegal_valid", out_valid, 1);
    checkOutput("div_illegal_result", out_result, 0);
    checkOutput("div_illegal_tag", out_tag, 8'h41);
    checkOutput("div_illegal_busy", busy, 0);
    tick();
    fop = OP_MUL;
`endif

    // back-pressure with rd=0: no forwarding, result held, next op waits
    out_ready = 1'b0;
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd2, 5'd0, 8'h05);
    tick();
    checkOutput("bp_valid", out_valid, 1);
    checkOutput("bp_result", out_result, 32'd3);
    checkOutput("bp_fwd_valid", fwd_valid, 0);
    applyStimulus(1'b1, OP_ADD, 32'd10, 32'd20, 5'd7, 8'h06);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_in_ready", in_ready, 0);
      tick();
      checkOutput("bp_hold_result", out_result, 32'd3);
      checkOutput("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", in_ready, 1);
    tick();
    checkOutput("bp_next_result", out_result, 32'd30);
    checkOutput("bp_next_rd", out_rd, 5'd7);
    applyStimulus(1'b0, OP_ADD, '0, '0, 5'd0, '0);
    tick();

    // flush on RUN cycle 10 of a long iterative op
    applyStimulus(1'b1, fop, 32'd1000, 32'd7, 5'd12, 8'h07);
    tick();
    applyStimulus(1'b0, OP_ADD, '0, '0, 5'd0, '0);
    checkOutput("flush_run_busy", busy, 1);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flush_busy", busy, 0);
    checkOutput("flush_out_valid", out_valid, 0);
    checkOutput("flush_in_ready", in_ready, 1);

    // an op presented together with flush is dropped
    flush = 1'b1;
    applyStimulus(1'b1, OP_ADD, 32'd9, 32'd9, 5'd13, 8'h00);
    #1;
    checkOutput("flush_blocks_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    checkOutput("flush_dropped_op", out_valid, 0);
    issueAlu("post_flush_add", OP_ADD, 32'd40, 32'd2, 5'd14, 32'd42);
    applyStimulus(1'b0, OP_ADD, '0, '0, 5'd0, '0);
    tick();

    // reset in the middle of a multiply
    applyStimulus(1'b1, OP_MULHU, 32'hFFFF_FFFF, 32'd3, 5'd15, 8'h99);
    tick();
    applyStimulus(1'b0, OP_ADD, '0, '0, 5'd0, '0);
    repeat (5) tick();
    checkOutput("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_out_valid", out_valid, 0);
    checkOutput("rst_mid_out_result", out_result, 0);
    checkOutput("rst_mid_out_rd", out_rd, 0);
    checkOutput("rst_mid_out_tag", out_tag, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_fwd_data", fwd_data, 0);
    rst = 1'b0;
    tick();
    checkOutput("rst_mid_ready_after", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kamacore_stage_ex_mc.md
Name: kamacore_stage_ex_mc

Overview:
Parametrised multi-cycle execute stage for the kamacore pipeline. It replaces the single-cycle EX stage with a valid/ready-handshaked stage.
- Single-cycle ALU ops complete in 1 cycle.
- RV32M multiply/divide ops run on an iterative unit and back-pressure ID.
- Operands arrive already forwarded.
- The stage exports its registered result as a forwarding source for the next instructions.

Parameters:
XLEN, 32, datapath width (32 or 64)
TAG_W, 8, width of opaque metadata (control signals) passed through unchanged
MUL_STEP, 1, multiplier bits retired per iteration (1, 2 or 4; must divide XLEN)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  kill in-flight op and output register
in_valid  input  1  ID/EX has an op
in_ready  output  1  stage accepts op this cycle
in_op  input  ex_op_t  decoded operation
in_rs1  input  XLEN  forwarded source 1
in_rs2  input  XLEN  forwarded source 2 (or immediate)
in_rd  input  5  destination register
in_tag  input  TAG_W  passthrough metadata
out_valid  output  1  EX/MEM register holds a result
out_ready  input  1  MEM consumes result
out_result  output  XLEN  result
out_rd  output  5  destination
out_tag  output  TAG_W  metadata
busy  output  1  iterative unit in RUN
fwd_valid  output  1  out_valid && out_rd!=0
fwd_rd  output  5  equals out_rd
fwd_data  output  XLEN  equals out_result

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. Reset values: out_valid=0, out_result=0, out_rd=0, out_tag=0, busy=0, FSM=IDLE, counter=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready); an op is accepted on in_valid && in_ready.
- ALU ops (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI-pass) are computed combinationally. They load the output register at the accepting edge: latency 1.
- MUL ops (MUL, MULH, MULHSU, MULHU):
  - Accepting edge latches operands and moves FSM IDLE->RUN, counter = XLEN/MUL_STEP.
  - Each RUN cycle retires MUL_STEP bits and decrements the counter.
  - When the counter reaches 0: RUN->DONE. The product is a 2*XLEN signed/unsigned product per op; the low or high half is selected.
- DIV ops (DIV, DIVU, REM, REMU): restoring radix-2, XLEN RUN cycles, then DONE.
  - Divide by zero: quotient = all ones, remainder = rs1. Takes 1 RUN cycle (early out).
  - DIV/REM with rs1 = -2^(XLEN-1), rs2 = -1: quotient = rs1, remainder = 0. Takes 1 RUN cycle.
- DONE: load output register when !out_valid || out_ready, then go to IDLE. Otherwise hold in DONE.
- Output register: holds its value while out_valid && !out_ready. A new load in the same cycle as out_ready is allowed (full throughput for ALU ops).
- flush:
  - Next edge: out_valid=0, FSM=IDLE, counter=0.
  - An op presented with flush is not accepted (in_ready forced 0).
  - flush has priority over every other event except rst.
- Reset mid-operation: same as flush, and all registers take their reset values.
- Widths: shifts use rs2[$clog2(XLEN)-1:0]. All arithmetic wraps modulo 2^XLEN.

Optional Feature:
KAMACORE_EX_DIV_EN.
- Defined: divider logic present, DIV-family ops behave as above.
- Undefined: divider logic is removed. DIV-family ops complete in 1 cycle with out_result=0 and out_tag bit 0 forced to 1 (illegal-instruction flag); MUL is unaffected.

Decomposition:
- kamacore_pkg holds:
  - typedef enum ex_op_t (5 bits).
  - Helper functions is_mul(op) and is_div(op).
  - Constants DIV0_QUOT (all ones) and REG_ZERO (5'd0).
- Sub-module kamacore_muldiv_iter contains the FSM, counter, shift-add multiplier and restoring divider.
  - Handshake: start, op, a, b in; done, result out.
  - The stage top holds the ALU, the output register and the handshake.

Test Plan:
- ADD with rs1=5, rs2=7, rd=3, out_ready=1 -> next cycle out_valid=1, out_result=12, fwd_valid=1, fwd_rd=3; back-to-back ADDs sustain one result per cycle.
- MUL 0xFFFFFFFF x 0xFFFFFFFF as MULHU (XLEN=32, MUL_STEP=1) -> busy for 32 cycles, in_ready=0 throughout, out_result=0xFFFFFFFE; MULH on the same operands -> 0x00000000.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0; DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100.
- out_ready held 0 for 5 cycles with a result valid -> out_result stable, in_ready=0, no op lost; a result with rd=0 gives fwd_valid=0.
- flush asserted on RUN cycle 10 of a DIV -> next cycle busy=0, out_valid=0, in_ready=1; the following ADD produces its correct result.
- Build without KAMACORE_EX_DIV_EN, issue DIV -> 1-cycle latency, out_result=0, out_tag[0]=1; rst asserted mid-MUL -> all outputs return to 0 next edge.
